// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_pkg
// Purpose  : Shared definitions for the parallel-in serial-out transmitter.
//            The transmitter state encoding and the default word width are
//            kept here so the matching SIPO receiver uses the same width.
// Contents : state_e             - transmitter FSM states
//            PISO_DEFAULT_WIDTH  - default bits per serial word
// Revision : 1.0 - initial release
// ============================================================================
package piso_pkg;

  localparam int unsigned PISO_DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_if
// Purpose  : Load handshake and serial output bundle of the PISO transmitter.
// Signals  : load_data  [WIDTH] word to transmit (source -> transmitter)
//            load_valid         load_data is valid (source -> transmitter)
//            load_ready         word accepted when valid && ready
//            q                  serial data bit
//            q_valid            q carries a data bit this cycle
//            first              q carries the first bit of a word
//            last               q carries the last bit of a word
// Modports : master - word source / serial sink side
//            slave  - transmitter side
// Revision : 1.0 - initial release
// ============================================================================
interface piso_tx_if
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             q;
  logic             q_valid;
  logic             first;
  logic             last;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  q,
    input  q_valid,
    input  first,
    input  last
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output q,
    output q_valid,
    output first,
    output last
  );

endinterface : piso_tx_if
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_core
// Purpose  : Loadable WIDTH-bit serialiser register. Direction is chosen by
//            MSB_FIRST. first_bit is the bit that leads the word being
//            loaded; next_bit is the bit that follows the one currently on
//            the serial line.
// Ports    : clk        in   clock
//            rst        in   asynchronous active-high reset
//            i_load     in   capture i_data this edge
//            i_shift    in   advance one bit this edge
//            i_data     in   [WIDTH] word to capture
//            o_first_bit out leading bit of i_data
//            o_next_bit  out bit to put on the line at the next shift
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic             i_shift,
  input  wire logic [WIDTH-1:0] i_data,
  output logic                  o_first_bit,
  output logic                  o_next_bit
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] w_rotated;

  // The register rotates rather than shifting in zeros: the word is held
  // intact, and the bit after the one on the line always sits next to the
  // leading end. The leading bit itself goes straight to the output flop on
  // load, so the lookahead starts one position in.
  if (MSB_FIRST) begin : g_msb_first
    assign w_rotated   = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
    assign o_next_bit  = sreg_q[WIDTH-2];
    assign o_first_bit = i_data[WIDTH-1];
  end else begin : g_lsb_first
    assign w_rotated   = {sreg_q[0], sreg_q[WIDTH-1:1]};
    assign o_next_bit  = sreg_q[1];
    assign o_first_bit = i_data[0];
  end

  always_comb begin
    sreg_d = sreg_q;
    if (i_load) begin
      sreg_d = i_data;
    end else if (i_shift) begin
      sreg_d = w_rotated;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule : piso_shift_core
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx
// Purpose  : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on
//            a valid/ready handshake and sends it one bit per clock on a
//            registered serial line. Back-to-back words stream with no gap.
// Ports    : clk   in  rising-edge clock
//            rst   in  asynchronous active-high reset
//            bus   piso_tx_if.slave (load_data/load_valid/load_ready,
//                  q/q_valid/first/last)
// Params   : WIDTH      bits per word (>= 2)
//            MSB_FIRST  1: bit WIDTH-1 first, 0: bit 0 first
//            IDLE_LEVEL level driven on q between words
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  piso_tx_if.slave  bus
);

  localparam int C_CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic               q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;

  logic w_load_ready;
  logic w_accept;
  logic w_shift;
  logic w_first_bit;
  logic w_next_bit;

  // A new word may be taken while idle, or while the final bit of the
  // current word is on the line, which is what removes the idle gap.
  assign w_load_ready = !rst && ((state_q == ST_IDLE) || last_q);
  assign w_accept     = bus.load_valid && w_load_ready;

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_shift     (w_shift),
    .i_data      (bus.load_data),
    .o_first_bit (w_first_bit),
    .o_next_bit  (w_next_bit)
  );

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    first_d   = 1'b0;
    last_d    = 1'b0;
    cnt_d     = cnt_q;
    w_shift   = 1'b0;

    if (w_accept) begin
      state_d   = ST_SHIFT;
      q_d       = w_first_bit;
      q_valid_d = 1'b1;
      first_d   = 1'b1;
      cnt_d     = C_CNT_W'(WIDTH - 1);
    end else if (state_q == ST_SHIFT) begin
      if (last_q) begin
        state_d   = ST_IDLE;
        q_d       = IDLE_LEVEL;
        q_valid_d = 1'b0;
      end else begin
        w_shift   = 1'b1;
        q_d       = w_next_bit;
        q_valid_d = 1'b1;
        // cnt counts the bits still to come after the one on the line.
        last_d    = (cnt_q == C_CNT_W'(1));
        cnt_d     = cnt_q - C_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      q_q       <= IDLE_LEVEL;
      q_valid_q <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.q          = q_q;
  assign bus.q_valid    = q_valid_q;
  assign bus.first      = first_q;
  assign bus.last       = last_q;

endmodule : piso_tx
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx
// Purpose  : Self-checking bench for piso_tx. Two transmitters (MSB-first and
//            LSB-first) share one stimulus; a word/bit-index model predicts
//            every output, and a 4-stage chain on the MSB-first line is
//            compared against the predicted line delayed by four edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ld;
  logic         lv;
  logic [3:0]   chain;

  int errors = 0;
  int checks = 0;

  // Reference model: the word in flight, the index of the bit on the line,
  // and whether a word is being sent at all.
  logic [W-1:0] m_word;
  int           m_k;
  bit           m_act;
  logic [3:0]   m_hist;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) if_m ();
  piso_tx_if #(.WIDTH(W)) if_l ();

  assign if_m.load_data  = ld;
  assign if_m.load_valid = lv;
  assign if_l.load_data  = ld;
  assign if_l.load_valid = lv;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (if_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (if_l)
  );

  // Downstream 4-stage serial chain fed by the MSB-first line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[2:0], if_m.q};
  end

  function automatic logic exp_ready();
    return !rst && (!m_act || (m_k == W - 1));
  endfunction

  function automatic logic exp_q(input bit msb);
    if (!m_act) return 1'b0;
    return msb ? m_word[W-1-m_k] : m_word[m_k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_m", 32'(if_m.load_ready), 32'(exp_ready()));
    chk("ready_l", 32'(if_l.load_ready), 32'(exp_ready()));
    chk("q_m",     32'(if_m.q),          32'(exp_q(1'b1)));
    chk("q_l",     32'(if_l.q),          32'(exp_q(1'b0)));
    chk("qv_m",    32'(if_m.q_valid),    32'(m_act));
    chk("qv_l",    32'(if_l.q_valid),    32'(m_act));
    chk("first_m", 32'(if_m.first),      32'(m_act && (m_k == 0)));
    chk("first_l", 32'(if_l.first),      32'(m_act && (m_k == 0)));
    chk("last_m",  32'(if_m.last),       32'(m_act && (m_k == W - 1)));
    chk("last_l",  32'(if_l.last),       32'(m_act && (m_k == W - 1)));
    chk("chain",   32'(chain[3]),        32'(m_hist[3]));
  endtask

  task automatic model_reset();
    m_word = '0;
    m_k    = 0;
    m_act  = 1'b0;
    m_hist = '0;
  endtask

  // One clock: decide acceptance from the model before the edge, advance the
  // model at the edge, compare on the following falling edge.
  task automatic cycle();
    bit acc;
    acc = lv && exp_ready();
    @(posedge clk);
    m_hist = {m_hist[2:0], exp_q(1'b1)};
    if (acc) begin
      m_word = ld;
      m_k    = 0;
      m_act  = 1'b1;
    end else if (m_act) begin
      if (m_k == W - 1) m_act = 1'b0;
      else              m_k++;
    end
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset asserted part-way through the low... high phase.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_q",     32'(if_m.q),          32'd0);
    chk("rst_qv",    32'(if_m.q_valid),    32'd0);
    chk("rst_ready", 32'(if_m.load_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(if_m.load_ready), 32'd1);
    check_all();
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    lv  = 1'b0;
    ld  = '0;
    model_reset();
    @(negedge clk);
    check_all();
    chk("reset_q", 32'(if_m.q), 32'd0);
    rst = 1'b0;
    #1;
    check_all();

    // Word 8'hC1 alone: MSB-first 1,1,0,0,0,0,0,1 and LSB-first 1,0,0,0,0,0,1,1.
    pat = 8'hC1;
    ld  = pat;
    lv  = 1'b1;
    cycle();
    lv  = 1'b0;
    ld  = 8'h5A;
    for (int i = 1; i <= 8; i++) begin
      chk("t1_q_msb", 32'(if_m.q), 32'(pat[8-i]));
      chk("t2_q_lsb", 32'(if_l.q), 32'(pat[i-1]));
      if (i < 8) cycle();
    end
    chk("t1_last8", 32'(if_m.last), 32'd1);
    cycle();
    chk("t1_idle_qv", 32'(if_m.q_valid), 32'd0);
    chk("t1_idle_q",  32'(if_m.q),       32'd0);
    for (int i = 0; i < 6; i++) cycle();

    // Back-to-back 8'hC1 then 8'h3C: sixteen contiguous valid bits.
    ld = 8'hC1;
    lv = 1'b1;
    cycle();
    ld = 8'h3C;
    for (int i = 2; i <= 16; i++) begin
      cycle();
      if (i == 8) chk("t3_last8", 32'(if_m.last), 32'd1);
      if (i == 9) begin
        chk("t3_first9", 32'(if_m.first), 32'd1);
        lv = 1'b0;
      end
      chk("t3_qv", 32'(if_m.q_valid), 32'd1);
    end
    chk("t3_last16", 32'(if_m.last), 32'd1);
    cycle();
    chk("t3_gap", 32'(if_m.q_valid), 32'd0);
    cycle();

    // 8'hFF with a held, refused 8'h00 behind it.
    ld = 8'hFF;
    lv = 1'b1;
    cycle();
    ld = 8'h00;
    for (int i = 2; i <= 9; i++) begin
      cycle();
      if (i <= 7) chk("t4_ready_low", 32'(if_m.load_ready), 32'd0);
      if (i <= 8) chk("t4_q_one",     32'(if_m.q),          32'd1);
    end
    chk("t4_first_new", 32'(if_m.first), 32'd1);
    chk("t4_q_new",     32'(if_m.q),     32'd0);
    lv = 1'b0;
    for (int i = 0; i < 9; i++) cycle();

    // 8'hA5 aborted by reset in cycle 4, then 8'h81 sent cleanly.
    ld = 8'hA5;
    lv = 1'b1;
    cycle();
    lv = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    async_reset();
    pat = 8'h81;
    ld  = pat;
    lv  = 1'b1;
    cycle();
    lv  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t5_q", 32'(if_m.q), 32'(pat[8-i]));
      cycle();
    end
    for (int i = 0; i < 5; i++) cycle();

    // Chain delay: 8'hC1 reappears four edges later on the chain output.
    pat = 8'hC1;
    ld  = pat;
    lv  = 1'b1;
    cycle();
    lv  = 1'b0;
    for (int i = 2; i <= 12; i++) begin
      cycle();
      if (i >= 5) chk("t6_chain", 32'(chain[3]), 32'(pat[8-(i-4)]));
    end

    // Random traffic, with data changing under refused requests.
    for (int i = 0; i < 400; i++) begin
      lv = ($urandom_range(0, 3) != 0);
      ld = W'($urandom);
      cycle();
      if (i == 200) async_reset();
    end
    lv = 1'b0;
    for (int i = 0; i < 12; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_piso_tx
`default_nettype wire
